// File: rtl/cmp_stim_checker.sv
// Self-test stimulus driver for an N-bit magnitude comparator. It sweeps every (A,B) pair
// and checks the one-hot result R_in against a golden compare, reporting errors and the first fail.
module cmp_stim_checker #(
  parameter int unsigned N      = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [N-1:0] A_out,
  output logic [N-1:0] B_out,
  input  logic [2:0]   R_in,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [2*N:0] err_count,
  output logic         fail_valid,
  output logic [N-1:0] fail_a,
  output logic [N-1:0] fail_b
);

  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  // Counter is loaded with SETTLE-1 so WAIT lasts exactly SETTLE cycles; unused when SETTLE=0.
  localparam logic [CntW-1:0] WaitLoad = CntW'(SETTLE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StWait,
    StCheck,
    StDone
  } state_e;

  state_e          state;
  logic [CntW-1:0] wait_cnt;

  logic [2:0]     expected;
  logic           mismatch;
  logic           last_vec;
  logic [2*N-1:0] pair_inc;
  logic [2*N:0]   err_inc;

  always_comb begin
    expected = 3'b001;
    if (A_out > B_out) begin
      expected = 3'b100;
    end else if (A_out == B_out) begin
      expected = 3'b010;
    end
    // Any non-one-hot R_in also differs from expected, so it counts as a mismatch.
    mismatch = (R_in != expected);
    err_inc  = err_count + (2*N+1)'(mismatch);
    last_vec = &{A_out, B_out};
    // B occupies the low bits, so it is the inner loop of the sweep.
    pair_inc = {A_out, B_out} + (2*N)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      wait_cnt   <= '0;
      A_out      <= '0;
      B_out      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
    end else begin
      unique case (state)
        StIdle, StDone: begin
          if (start) begin
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            A_out      <= '0;
            B_out      <= '0;
            busy       <= 1'b1;
            state      <= StDrive;
          end
        end
        StDrive: begin
          if (SETTLE > 0) begin
            wait_cnt <= WaitLoad;
            state    <= StWait;
          end else begin
            state <= StCheck;
          end
        end
        StWait: begin
          if (wait_cnt == '0) begin
            state <= StCheck;
          end else begin
            wait_cnt <= wait_cnt - CntW'(1);
          end
        end
        StCheck: begin
          err_count <= err_inc;
          if (mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_a     <= A_out;
            fail_b     <= B_out;
          end
          if (last_vec) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_inc == '0);
            state <= StDone;
          end else begin
            {A_out, B_out} <= pair_inc;
            state          <= StDrive;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_stim_checker.sv
// Directed bench for cmp_stim_checker: three instances (SETTLE=1, 0, 3) each driving a
// behavioural comparator model that can be ideal, faulty or delayed.
module tb_cmp_stim_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int mode   = 0;  // dut1 comparator: 0 ideal, 1 R[1] stuck 0, 2 gt/lt swapped

  logic       start1, start0, start3;
  logic [3:0] a1, b1, a0, b0, a3, b3, fa1, fb1, fa0, fb0, fa3, fb3;
  logic [2:0] r1, r0, r3, r3_d1, r3_d2;
  logic       busy1, done1, pass1, fv1;
  logic       busy0, done0, pass0, fv0;
  logic       busy3, done3, pass3, fv3;
  logic [8:0] err1, err0, err3;

  function automatic logic [2:0] cmp_ideal(input logic [3:0] a, input logic [3:0] b);
    if (a > b) return 3'b100;
    if (a == b) return 3'b010;
    return 3'b001;
  endfunction

  always_comb begin
    r1 = cmp_ideal(a1, b1);
    case (mode)
      1: r1 = cmp_ideal(a1, b1) & 3'b101;
      2: r1 = {cmp_ideal(a1, b1) == 3'b001, cmp_ideal(a1, b1) == 3'b010,
               cmp_ideal(a1, b1) == 3'b100};
      default: r1 = cmp_ideal(a1, b1);
    endcase
  end

  assign r0 = cmp_ideal(a0, b0);

  // Comparator with a 2-cycle result latency.
  always @(posedge clk) begin
    r3_d1 <= cmp_ideal(a3, b3);
    r3_d2 <= r3_d1;
  end
  assign r3 = r3_d2;

  cmp_stim_checker #(.N(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A_out(a1), .B_out(b1), .R_in(r1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_valid(fv1),
    .fail_a(fa1), .fail_b(fb1)
  );

  cmp_stim_checker #(.N(4), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .A_out(a0), .B_out(b0), .R_in(r0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_valid(fv0),
    .fail_a(fa0), .fail_b(fb0)
  );

  cmp_stim_checker #(.N(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .A_out(a3), .B_out(b3), .R_in(r3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .fail_valid(fv3),
    .fail_a(fa3), .fail_b(fb3)
  );

  task automatic pulse_start1();
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
  endtask

  task automatic wait_done1(output int cycles, output int busy_low);
    cycles   = 0;
    busy_low = 0;
    while (done1 !== 1'b1 && cycles < 2000) begin
      if (busy1 !== 1'b1) busy_low++;
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b1;
    start1 = 1'b0;
    start0 = 1'b0;
    start3 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (a1 !== 4'd0 || b1 !== 4'd0) begin errors++;
      $display("FAIL reset_ab: got %0d,%0d expected 0,0", a1, b1); end
    checks++; if ({busy1, done1, pass1, fv1} !== 4'b0) begin errors++;
      $display("FAIL reset_flags: got %b expected 0000", {busy1, done1, pass1, fv1}); end
    checks++; if (err1 !== 9'd0 || fa1 !== 4'd0 || fb1 !== 4'd0) begin errors++;
      $display("FAIL reset_err: got %0d,%0d,%0d expected 0,0,0", err1, fa1, fb1); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy1 !== 1'b0 || busy0 !== 1'b0 || busy3 !== 1'b0) begin errors++;
      $display("FAIL idle_no_start: got %b%b%b expected 000", busy1, busy0, busy3); end
  endtask

  task automatic test_ideal();
    int cyc, bl;
    mode = 0;
    pulse_start1();
    wait_done1(cyc, bl);
    checks++; if (cyc !== 768) begin errors++;
      $display("FAIL ideal_cycles: got %0d expected 768", cyc); end
    checks++; if (bl !== 0) begin errors++;
      $display("FAIL ideal_busy: got %0d busy-low cycles expected 0", bl); end
    checks++; if ({done1, pass1, busy1, fv1} !== 4'b1100) begin errors++;
      $display("FAIL ideal_flags: got %b expected 1100", {done1, pass1, busy1, fv1}); end
    checks++; if (err1 !== 9'd0) begin errors++;
      $display("FAIL ideal_err: got %0d expected 0", err1); end
    checks++; if (a1 !== 4'd15 || b1 !== 4'd15) begin errors++;
      $display("FAIL ideal_hold_ab: got %0d,%0d expected 15,15", a1, b1); end
  endtask

  task automatic test_stuck_eq();
    int cyc, bl;
    mode = 1;
    pulse_start1();
    wait_done1(cyc, bl);
    checks++; if (cyc !== 768 || done1 !== 1'b1) begin errors++;
      $display("FAIL stuck_cycles: got %0d expected 768", cyc); end
    checks++; if (pass1 !== 1'b0 || err1 !== 9'd16) begin errors++;
      $display("FAIL stuck_err: got pass=%b err=%0d expected pass=0 err=16", pass1, err1); end
    checks++; if (fv1 !== 1'b1 || fa1 !== 4'd0 || fb1 !== 4'd0) begin errors++;
      $display("FAIL stuck_first: got %b %0d,%0d expected 1 0,0", fv1, fa1, fb1); end
  endtask

  task automatic test_swap();
    int cyc = 0;
    int hold_bad = 0;
    mode = 2;
    pulse_start1();
    // Restart from DONE after a faulty sweep must clear the old results.
    checks++; if (err1 !== 9'd0 || done1 !== 1'b0 || fv1 !== 1'b0 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear: got err=%0d done=%b fv=%b busy=%b expected 0 0 0 1",
               err1, done1, fv1, busy1);
    end
    while (done1 !== 1'b1 && cyc < 2000) begin
      if (fv1 === 1'b1 && (fa1 !== 4'd0 || fb1 !== 4'd1)) hold_bad++;
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++; if (cyc !== 768) begin errors++;
      $display("FAIL swap_cycles: got %0d expected 768", cyc); end
    checks++; if (err1 !== 9'd240 || pass1 !== 1'b0) begin errors++;
      $display("FAIL swap_err: got err=%0d pass=%b expected 240 0", err1, pass1); end
    checks++; if (fv1 !== 1'b1 || fa1 !== 4'd0 || fb1 !== 4'd1) begin errors++;
      $display("FAIL swap_first: got %b %0d,%0d expected 1 0,1", fv1, fa1, fb1); end
    checks++; if (hold_bad !== 0) begin errors++;
      $display("FAIL swap_hold: got %0d changed cycles expected 0", hold_bad); end
  endtask

  task automatic test_busy_start();
    int cyc = 0;
    bit pulsed = 0;
    mode = 0;
    pulse_start1();
    while (done1 !== 1'b1 && cyc < 2000) begin
      if (!pulsed && a1 == 4'd5 && b1 == 4'd10) begin
        start1 = 1'b1;
        pulsed = 1;
      end
      @(posedge clk);
      #1;
      start1 = 1'b0;
      cyc++;
    end
    checks++; if (!pulsed || cyc !== 768) begin errors++;
      $display("FAIL busy_start: got pulsed=%0d cycles=%0d expected 1 768", pulsed, cyc); end
    checks++; if (pass1 !== 1'b1 || err1 !== 9'd0) begin errors++;
      $display("FAIL busy_start_pass: got %b %0d expected 1 0", pass1, err1); end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    int bl;
    mode = 2;
    pulse_start1();
    while (!(a1 == 4'd3 && b1 == 4'd2) && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++; if (cyc >= 2000 || err1 === 9'd0) begin errors++;
      $display("FAIL mid_reach: got cycles=%0d err=%0d expected vector (3,2) with errors",
               cyc, err1); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({a1, b1, fa1, fb1} !== 16'd0 || err1 !== 9'd0) begin errors++;
      $display("FAIL mid_reset_data: got ab=%0d,%0d err=%0d fail=%0d,%0d expected zeros",
               a1, b1, err1, fa1, fb1); end
    checks++; if ({busy1, done1, pass1, fv1} !== 4'b0) begin errors++;
      $display("FAIL mid_reset_flags: got %b expected 0000", {busy1, done1, pass1, fv1}); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mode  = 0;
    pulse_start1();
    wait_done1(cyc, bl);
    checks++; if (cyc !== 768 || pass1 !== 1'b1 || err1 !== 9'd0 || fv1 !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_sweep: got cycles=%0d pass=%b err=%0d expected 768 1 0",
               cyc, pass1, err1);
    end
  endtask

  task automatic test_settle();
    int c0 = -1;
    int c3 = -1;
    start0 = 1'b1;
    start3 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start3 = 1'b0;
    for (int i = 1; i <= 1400; i++) begin
      @(posedge clk);
      #1;
      if (done0 === 1'b1 && c0 < 0) c0 = i;
      if (done3 === 1'b1 && c3 < 0) c3 = i;
    end
    checks++; if (c0 !== 512) begin errors++;
      $display("FAIL settle0_cycles: got %0d expected 512", c0); end
    checks++; if (c3 !== 1280) begin errors++;
      $display("FAIL settle3_cycles: got %0d expected 1280", c3); end
    checks++; if (pass0 !== 1'b1 || err0 !== 9'd0) begin errors++;
      $display("FAIL settle0_pass: got %b %0d expected 1 0", pass0, err0); end
    checks++; if (pass3 !== 1'b1 || err3 !== 9'd0 || fv3 !== 1'b0) begin errors++;
      $display("FAIL settle3_latency_pass: got %b %0d expected 1 0", pass3, err3); end
  endtask

  task automatic test_start_held();
    int done_cnt = 0;
    int done_at  = -1;
    logic busy_after = 1'b0;
    mode   = 0;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 800; i++) begin
      @(posedge clk);
      #1;
      if (done1 === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      if (i == 769) busy_after = busy1;
    end
    start1 = 1'b0;
    checks++; if (done_cnt !== 1 || done_at !== 768) begin errors++;
      $display("FAIL held_done: got count=%0d at=%0d expected 1 at 768", done_cnt, done_at); end
    checks++; if (busy_after !== 1'b1) begin errors++;
      $display("FAIL held_restart: got busy=%b expected 1", busy_after); end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_stuck_eq();
    test_swap();
    test_busy_start();
    test_reset_mid();
    test_settle();
    test_start_held();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
